// File: rtl/hazard_stall_controller.sv
// Pipeline hazard and stall sequencer for the 5-stage core.
// Drives IF/ID stall/flush and ID/EX bubble; drains the pipe before traps.
module hazard_stall_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wb_reg_file,
  input  logic                  id_wb_load,
  input  logic                  id_invalid_inst,
  input  logic                  ex_branch_taken,
  input  logic                  mem_stall,
  input  logic                  trap_ack,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  trap_req,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t                state;
  logic                  ex_vld;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_wr;
  logic                  ex_ld;
  logic                  mem_vld;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_wr;

  logic load_use;
  logic issued;
  logic in_run;

  // Destination info beyond EX is kept for forwarding hookup later
  logic unused_trk;
  assign unused_trk = ^{mem_rd, mem_wr, ex_wr};

  assign in_run = (state == RUN);

  assign load_use = ex_vld & ex_ld & (ex_rd != '0) & id_valid &
                    ((id_rs1_used & (id_rs1 == ex_rd)) |
                     (id_rs2_used & (id_rs2 == ex_rd)));

  assign issued = id_valid & in_run & ~load_use &
                  ~ex_branch_taken & ~id_invalid_inst;

  assign trap_req = (state == TRAP);

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (mem_stall) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (in_run) begin
      if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end else begin
      // DRAIN and TRAP both hold the faulting instruction in ID
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
      if_id_flush  = (state == TRAP) & trap_ack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      ex_vld       <= 1'b0;
      ex_rd        <= '0;
      ex_wr        <= 1'b0;
      ex_ld        <= 1'b0;
      mem_vld      <= 1'b0;
      mem_rd       <= '0;
      mem_wr       <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pc_stall)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (!mem_stall) begin
        if (if_id_flush)
          flush_count <= flush_count + CNT_W'(1);
        mem_vld <= ex_vld;
        mem_rd  <= ex_rd;
        mem_wr  <= ex_wr;
        ex_vld  <= issued;
        ex_rd   <= issued ? id_rd : '0;
        ex_wr   <= issued & id_wb_reg_file;
        ex_ld   <= issued & id_wb_load;
        unique case (state)
          RUN: begin
            if (id_valid & id_invalid_inst & ~ex_branch_taken)
              state <= DRAIN;
          end
          DRAIN: begin
            if (ex_branch_taken)
              state <= RUN;
            else if (~ex_vld & ~mem_vld)
              state <= TRAP;
          end
          TRAP: begin
            if (trap_ack)
              state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller.
// Inputs change #1 after posedge; outputs sampled #1 later.
module tb_hazard_stall_controller;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_wb_reg_file;
  logic        id_wb_load;
  logic        id_invalid_inst;
  logic        ex_branch_taken;
  logic        mem_stall;
  logic        trap_ack;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        trap_req;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  int errors = 0;
  int checks = 0;

  hazard_stall_controller #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_wb_reg_file  (id_wb_reg_file),
    .id_wb_load      (id_wb_load),
    .id_invalid_inst (id_invalid_inst),
    .ex_branch_taken (ex_branch_taken),
    .mem_stall       (mem_stall),
    .trap_ack        (trap_ack),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .trap_req        (trap_req),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, trap_req}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_stall, if_id_stall, if_id_flush,
              id_ex_bubble, trap_req}, {27'd0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid        = 1'b0;
    id_rs1          = '0;
    id_rs2          = '0;
    id_rs1_used     = 1'b0;
    id_rs2_used     = 1'b0;
    id_rd           = '0;
    id_wb_reg_file  = 1'b0;
    id_wb_load      = 1'b0;
    id_invalid_inst = 1'b0;
    ex_branch_taken = 1'b0;
    mem_stall       = 1'b0;
    trap_ack        = 1'b0;
  endtask

  task automatic put_lw(input logic [4:0] rd);
    idle();
    id_valid       = 1'b1;
    id_rd          = rd;
    id_wb_reg_file = 1'b1;
    id_wb_load     = 1'b1;
  endtask

  task automatic put_alu(input logic [4:0] rd, input logic [4:0] rs1,
                         input logic u1, input logic [4:0] rs2,
                         input logic u2);
    idle();
    id_valid       = 1'b1;
    id_rd          = rd;
    id_rs1         = rs1;
    id_rs1_used    = u1;
    id_rs2         = rs2;
    id_rs2_used    = u2;
    id_wb_reg_file = 1'b1;
  endtask

  task automatic put_bad();
    idle();
    id_valid        = 1'b1;
    id_invalid_inst = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk_ctl("reset_ctl", 5'b00000);
    chk("reset_stall_cnt", stall_cycles, 32'd0);
    chk("reset_flush_cnt", flush_count, 32'd0);
    put_alu(5'd6, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    chk_ctl("reset_no_hazard", 5'b00000);
    idle();
    #1;
    rst_n = 1'b1;
    cyc();

    // Load-use: LW x5 then ADD using x5
    put_lw(5'd5);
    #1;
    chk_ctl("lu_lw_issue", 5'b00000);
    cyc();
    put_alu(5'd6, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    chk_ctl("lu_stall", 5'b11010);
    cyc();
    #1;
    chk_ctl("lu_release", 5'b00000);
    chk("lu_stall_cnt", stall_cycles, 32'd1);
    cyc();

    // rd==0 load and unused rs2 never stall
    put_lw(5'd0);
    cyc();
    put_alu(5'd7, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    chk_ctl("rd0_no_stall", 5'b00000);
    cyc();
    put_lw(5'd5);
    cyc();
    put_alu(5'd7, 5'd1, 1'b1, 5'd5, 1'b0);
    #1;
    chk_ctl("rs2_unused_no_stall", 5'b00000);
    cyc();

    // Branch outranks load-use
    put_lw(5'd5);
    cyc();
    put_alu(5'd6, 5'd5, 1'b1, 5'd0, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    chk_ctl("br_over_lu", 5'b00110);
    cyc();
    idle();
    #1;
    chk_ctl("br_after", 5'b00000);
    chk("br_flush_cnt", flush_count, 32'd1);
    cyc();

    // mem_stall freezes a pending load-use for 3 cycles
    put_lw(5'd5);
    cyc();
    put_alu(5'd6, 5'd5, 1'b1, 5'd0, 1'b0);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctl($sformatf("ms_hold%0d", i), 5'b11000);
      cyc();
    end
    mem_stall = 1'b0;
    #1;
    chk_ctl("ms_lu_after", 5'b11010);
    cyc();
    #1;
    chk_ctl("ms_release", 5'b00000);
    chk("ms_stall_cnt", stall_cycles, 32'd5);
    chk("ms_flush_cnt", flush_count, 32'd1);
    cyc();

    // Trap with EX and MEM occupied
    put_alu(5'd8, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    put_alu(5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    put_bad();
    #1;
    chk_ctl("tr_c0_detect", 5'b00000);
    cyc();
    #1;
    chk_ctl("tr_c1_drain", 5'b11010);
    cyc();
    #1;
    chk_ctl("tr_c2_drain", 5'b11010);
    cyc();
    #1;
    chk_ctl("tr_c3_req", 5'b11011);
    cyc();
    #1;
    chk_ctl("tr_c4_held", 5'b11011);
    cyc();
    trap_ack = 1'b1;
    #1;
    chk_ctl("tr_c5_ack", 5'b11111);
    cyc();
    idle();
    trap_ack = 1'b1;
    #1;
    chk_ctl("tr_c6_run_ack_ignored", 5'b00000);
    chk("tr_stall_cnt", stall_cycles, 32'd10);
    chk("tr_flush_cnt", flush_count, 32'd2);
    cyc();
    idle();

    // Branch during DRAIN cancels the trap
    put_alu(5'd8, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc();
    put_bad();
    cyc();
    ex_branch_taken = 1'b1;
    #1;
    chk_ctl("tc_branch_in_drain", 5'b00110);
    cyc();
    idle();
    #1;
    chk_ctl("tc_back_to_run", 5'b00000);
    cyc();
    #1;
    chk_ctl("tc_no_trap", 5'b00000);
    chk("tc_flush_cnt", flush_count, 32'd3);
    cyc();

    // Reset while in TRAP
    put_bad();
    cyc();
    idle();
    cyc();
    #1;
    chk_ctl("rt_in_trap", 5'b11011);
    rst_n = 1'b0;
    #1;
    chk("rt_trap_cleared", {31'd0, trap_req}, 32'd0);
    chk("rt_stall_cnt0", stall_cycles, 32'd0);
    chk("rt_flush_cnt0", flush_count, 32'd0);
    #1;
    rst_n = 1'b1;
    cyc();
    #1;
    chk_ctl("rt_run_after", 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
